// File: rtl/lock_seq_ctrl_if.sv
// Key-side and display/LED-side signals of the keypad lock sequencer.
// master: keypad encoder / display side; slave: the sequencer itself.
interface lock_seq_ctrl_if #(
  parameter int DW = 8
) ();
  logic          key_vld;
  logic [1:0]    key_sym;
  logic          clr;
  logic          chg;
  logic [DW-1:0] entry;
  logic [3:0]    cnt;
  logic [DW-1:0] code;
  logic          pass;
  logic          fail;
  logic          locked;
  logic          chg_mode;
  logic [1:0]    tries;

  modport master (
    output key_vld, key_sym, clr, chg,
    input  entry, cnt, code, pass, fail, locked, chg_mode, tries
  );

  modport slave (
    input  key_vld, key_sym, clr, chg,
    output entry, cnt, code, pass, fail, locked, chg_mode, tries
  );
endinterface

// File: rtl/lock_seq_ctrl.sv
// Keypad password lock sequencer: assembles 2-bit symbols into an attempt,
// checks it against the stored code, counts failures, enforces a timed
// lockout and runs the verified code-change procedure.
module lock_seq_ctrl #(
  parameter int DW       = 8,
  parameter int MAX_TRY  = 3,
  parameter int LOCK_CYC = 16,
  parameter int HOLD_CYC = 8
) (
  input  logic           clk,
  input  logic           rst,
  lock_seq_ctrl_if.slave bus
);

  localparam int TMAX = (LOCK_CYC > HOLD_CYC) ? LOCK_CYC : HOLD_CYC;
  localparam int TW   = $clog2(TMAX) + 1;

  localparam logic [3:0]    HALF    = 4'(DW / 2);
  localparam logic [TW-1:0] HOLD_LD = TW'(HOLD_CYC - 1);
  localparam logic [TW-1:0] LOCK_LD = TW'(LOCK_CYC - 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_ENTRY     = 3'd1;
  localparam logic [2:0] S_CHECK     = 3'd2;
  localparam logic [2:0] S_HOLD_P    = 3'd3;
  localparam logic [2:0] S_HOLD_F    = 3'd4;
  localparam logic [2:0] S_LOCK      = 3'd5;
  localparam logic [2:0] S_NEW_ENTRY = 3'd6;

  logic [2:0]    state_q, state_d;
  logic [DW-1:0] entry_q, entry_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [DW-1:0] code_q, code_d;
  logic          pass_q, pass_d;
  logic          fail_q, fail_d;
  logic          locked_q, locked_d;
  logic          chg_mode_q, chg_mode_d;
  logic [1:0]    tries_q, tries_d;
  logic [TW-1:0] timer_q, timer_d;

  // Next-state and registered-output computation for the sequencer FSM.
  always_comb begin
    state_d    = state_q;
    entry_d    = entry_q;
    cnt_d      = cnt_q;
    code_d     = code_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    locked_d   = locked_q;
    chg_mode_d = chg_mode_q;
    tries_d    = tries_q;
    timer_d    = timer_q;
    case (state_q)
      S_IDLE: begin
        if (bus.key_vld) begin
          entry_d = {entry_q[DW-3:0], bus.key_sym};
          cnt_d   = 4'd1;
          state_d = S_ENTRY;
        end else if (bus.chg) begin
          chg_mode_d = 1'b1;
          state_d    = S_ENTRY;
        end
      end
      // Symbol collection is shared; only the action taken once the entry is
      // full differs (compare against code vs. commit as the new code).
      S_ENTRY, S_NEW_ENTRY: begin
        if (bus.clr) begin
          entry_d    = '0;
          cnt_d      = '0;
          chg_mode_d = 1'b0;
          state_d    = S_IDLE;
        end else if (cnt_q == HALF) begin
          if (state_q == S_ENTRY) begin
            state_d = S_CHECK;
          end else begin
            code_d     = entry_q;
            chg_mode_d = 1'b0;
            pass_d     = 1'b1;
            timer_d    = HOLD_LD;
            state_d    = S_HOLD_P;
          end
        end else if (bus.key_vld) begin
          entry_d = {entry_q[DW-3:0], bus.key_sym};
          cnt_d   = cnt_q + 4'd1;
        end
      end
      S_CHECK: begin
        if (entry_q == code_q) begin
          if (chg_mode_q) begin
            entry_d = '0;
            cnt_d   = '0;
            state_d = S_NEW_ENTRY;
          end else begin
            tries_d = '0;
            pass_d  = 1'b1;
            timer_d = HOLD_LD;
            state_d = S_HOLD_P;
          end
        end else begin
          chg_mode_d = 1'b0;
          if (int'(tries_q) + 1 < MAX_TRY) begin
            tries_d = tries_q + 2'd1;
            fail_d  = 1'b1;
            timer_d = HOLD_LD;
            state_d = S_HOLD_F;
          end else begin
            entry_d  = '0;
            cnt_d    = '0;
            locked_d = 1'b1;
            fail_d   = 1'b1;
            timer_d  = LOCK_LD;
            state_d  = S_LOCK;
          end
        end
      end
      S_HOLD_P: begin
        if (timer_q == '0) begin
          pass_d     = 1'b0;
          entry_d    = '0;
          cnt_d      = '0;
          chg_mode_d = 1'b0;
          state_d    = S_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_HOLD_F: begin
        if (timer_q == '0) begin
          fail_d  = 1'b0;
          entry_d = '0;
          cnt_d   = '0;
          state_d = S_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      S_LOCK: begin
        if (timer_q == '0) begin
          locked_d = 1'b0;
          fail_d   = 1'b0;
          tries_d  = '0;
          entry_d  = '0;
          cnt_d    = '0;
          state_d  = S_IDLE;
        end else begin
          timer_d = timer_q - TW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      entry_q    <= '0;
      cnt_q      <= '0;
      code_q     <= '1;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      locked_q   <= 1'b0;
      chg_mode_q <= 1'b0;
      tries_q    <= '0;
      timer_q    <= '0;
    end else begin
      state_q    <= state_d;
      entry_q    <= entry_d;
      cnt_q      <= cnt_d;
      code_q     <= code_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      locked_q   <= locked_d;
      chg_mode_q <= chg_mode_d;
      tries_q    <= tries_d;
      timer_q    <= timer_d;
    end
  end

  assign bus.entry    = entry_q;
  assign bus.cnt      = cnt_q;
  assign bus.code     = code_q;
  assign bus.pass     = pass_q;
  assign bus.fail     = fail_q;
  assign bus.locked   = locked_q;
  assign bus.chg_mode = chg_mode_q;
  assign bus.tries    = tries_q;

endmodule

// File: tb/tb_lock_seq_ctrl.sv
// Directed bench for lock_seq_ctrl with default parameters.
module tb_lock_seq_ctrl;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  lock_seq_ctrl_if #(.DW(8)) bus ();

  lock_seq_ctrl #(
    .DW(8), .MAX_TRY(3), .LOCK_CYC(16), .HOLD_CYC(8)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic press(input logic [1:0] s);
    bus.key_vld = 1'b1;
    bus.key_sym = s;
    tick();
    bus.key_vld = 1'b0;
  endtask

  // Four symbols, oldest in bits [7:6].
  task automatic attempt(input logic [7:0] v);
    for (int i = 0; i < 4; i++) press(v[7-2*i -: 2]);
  endtask

  // Counts cycles of pass/fail/locked after an attempt; bounded.
  task automatic measure(input bit has_check, output int np, output int nf, output int nl);
    np = 0; nf = 0; nl = 0;
    if (has_check) begin
      tick();
      chk("check_cycle_quiet", {29'd0, bus.pass, bus.fail, bus.locked}, 0);
    end
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!(bus.pass || bus.fail || bus.locked)) break;
      if (bus.pass && bus.fail) chk("pass_fail_excl", 1, 0);
      np += int'(bus.pass);
      nf += int'(bus.fail);
      nl += int'(bus.locked);
    end
  endtask

  int np, nf, nl, good;

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0; bad = 0;
    rst = 1'b1;
    bus.key_vld = 1'b0; bus.key_sym = 2'd0; bus.clr = 1'b0; bus.chg = 1'b0;
    tick(); tick();
    rst = 1'b0;

    // Reset state
    chk("rst_code", bus.code, 8'hFF);
    chk("rst_entry", bus.entry, 0);
    chk("rst_cnt", bus.cnt, 0);
    chk("rst_tries", bus.tries, 0);
    chk("rst_flags", {bus.pass, bus.fail, bus.locked, bus.chg_mode}, 0);

    // Correct code with cnt stepping and pass latency/duration
    for (int i = 1; i <= 4; i++) begin
      press(2'd3);
      chk("s1_cnt", bus.cnt, i);
    end
    chk("s1_entry", bus.entry, 8'hFF);
    measure(1, np, nf, nl);
    chk("s1_pass_len", np, 8);
    chk("s1_fail_len", nf, 0);
    chk("s1_tries", bus.tries, 0);
    chk("s1_cleared", {bus.entry, bus.cnt}, 0);

    // Two wrong attempts then correct
    attempt(8'h1B);
    chk("s2_entry", bus.entry, 8'h1B);
    measure(1, np, nf, nl);
    chk("s2_fail1_len", nf, 8);
    chk("s2_pass1_len", np, 0);
    chk("s2_tries1", bus.tries, 1);
    attempt(8'h1B);
    measure(1, np, nf, nl);
    chk("s2_fail2_len", nf, 8);
    chk("s2_tries2", bus.tries, 2);
    attempt(8'hFF);
    measure(1, np, nf, nl);
    chk("s2_pass_len", np, 8);
    chk("s2_tries0", bus.tries, 0);

    // Lockout after three failures, keys ignored meanwhile
    attempt(8'h1B); measure(1, np, nf, nl);
    attempt(8'h1B); measure(1, np, nf, nl);
    chk("s3_tries2", bus.tries, 2);
    attempt(8'h1B);
    tick();
    chk("s3_check_quiet", {bus.fail, bus.locked}, 0);
    good = 0;
    for (int i = 0; i < 16; i++) begin
      bus.key_vld = (i % 3 == 0);
      bus.key_sym = 2'd2;
      tick();
      if (bus.locked && bus.fail && !bus.pass && bus.cnt == 0 && bus.entry == 0) good++;
    end
    bus.key_vld = 1'b0;
    chk("s3_lock_cycles", good, 16);
    tick();
    chk("s3_unlocked", {bus.locked, bus.fail}, 0);
    chk("s3_tries0", bus.tries, 0);
    chk("s3_cnt0", bus.cnt, 0);
    press(2'd2);
    chk("s3_idle_accepts", bus.cnt, 1);
    bus.clr = 1'b1; tick(); bus.clr = 1'b0;
    chk("s3_clr", bus.cnt, 0);

    // Code change procedure
    bus.chg = 1'b1; tick(); bus.chg = 1'b0;
    chk("s4_chg_mode", bus.chg_mode, 1);
    chk("s4_cnt0", bus.cnt, 0);
    attempt(8'hFF);
    chk("s4_chg_mode_v", bus.chg_mode, 1);
    tick();
    chk("s4_check_quiet", {bus.pass, bus.fail}, 0);
    tick();
    chk("s4_new_entry", {bus.chg_mode, bus.cnt, bus.entry}, {1'b1, 12'h000});
    attempt(8'h63);
    chk("s4_entry", bus.entry, 8'h63);
    chk("s4_code_old", bus.code, 8'hFF);
    chk("s4_chg_mode_n", bus.chg_mode, 1);
    measure(0, np, nf, nl);
    chk("s4_commit_pass", np, 8);
    chk("s4_code_new", bus.code, 8'h63);
    chk("s4_chg_mode_off", bus.chg_mode, 0);
    attempt(8'hFF);
    measure(1, np, nf, nl);
    chk("s4_old_fails", nf, 8);
    chk("s4_tries1", bus.tries, 1);
    attempt(8'h63);
    measure(1, np, nf, nl);
    chk("s4_new_passes", np, 8);
    chk("s4_tries0", bus.tries, 0);

    // clr with key_vld, then reset during lockout
    attempt(8'h1B); measure(1, np, nf, nl);
    press(2'd1); press(2'd2);
    chk("s6_entry12", bus.entry, 8'h06);
    chk("s6_cnt2", bus.cnt, 2);
    bus.clr = 1'b1; bus.key_vld = 1'b1; bus.key_sym = 2'd3;
    tick();
    bus.clr = 1'b0; bus.key_vld = 1'b0;
    chk("s6_clr_entry", bus.entry, 0);
    chk("s6_clr_cnt", bus.cnt, 0);
    chk("s6_clr_tries", bus.tries, 1);
    attempt(8'h1B); measure(1, np, nf, nl);
    chk("s6_tries2", bus.tries, 2);
    attempt(8'h1B);
    tick(); tick(); tick();
    chk("s6_locked", bus.locked, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("s6_rst_code", bus.code, 8'hFF);
    chk("s6_rst_all", {bus.entry, bus.cnt, bus.tries, bus.pass, bus.fail, bus.locked, bus.chg_mode}, 0);
    press(2'd1);
    chk("s6_rst_idle", bus.cnt, 1);
    bus.clr = 1'b1; tick(); bus.clr = 1'b0;

    // Failed verification aborts the change
    bus.chg = 1'b1; tick(); bus.chg = 1'b0;
    chk("s5_chg_mode", bus.chg_mode, 1);
    attempt(8'h00);
    measure(1, np, nf, nl);
    chk("s5_fail_len", nf, 8);
    chk("s5_chg_mode0", bus.chg_mode, 0);
    chk("s5_code", bus.code, 8'hFF);
    chk("s5_tries1", bus.tries, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/lock_seq_ctrl.md
Name: lock_seq_ctrl

Overview:
- Sequencing controller for the keypad password lock.
- Accepts debounced 2-bit key symbols and assembles them into a DW-bit attempt.
- Checks each attempt against the stored code, counts failed tries and enforces a timed lockout.
- Runs the verified code-change procedure.
- Sits between the key debouncer/encoder and the seven-segment display. Its entry and count outputs drive the display; pass, fail and locked drive the LEDs.

Parameters:
- DW, 8, code width in bits. Holds DW/2 2-bit symbols. Must be even, 4..16.
- MAX_TRY, 3, consecutive failed attempts that trigger lockout (1..3).
- LOCK_CYC, 16, lockout duration in clk cycles.
- HOLD_CYC, 8, cycles that pass/fail stay asserted after a check.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- key_vld  in  1  one-cycle strobe: key_sym is valid.
- key_sym  in  2  entered symbol, 0..3.
- clr  in  1  one-cycle strobe: abort the current entry.
- chg  in  1  one-cycle strobe: request a code change.
- entry  out  DW  symbols entered so far, newest in bits [1:0].
- cnt  out  4  number of symbols entered (0..DW/2).
- code  out  DW  stored code.
- pass  out  1  attempt accepted.
- fail  out  1  attempt rejected, or lockout active.
- locked  out  1  lockout active.
- chg_mode  out  1  code-change procedure in progress.
- tries  out  2  consecutive failed attempts.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - code = all ones.
  - entry=0, cnt=0, tries=0.
  - pass, fail, locked, chg_mode all 0.
  - State = IDLE; internal timer = 0.
  - Reset mid-operation aborts everything, including a lockout, and restores the default code.
- States: IDLE, ENTRY, CHECK, HOLD_P, HOLD_F, LOCK, NEW_ENTRY.
- IDLE:
  - key_vld: entry={entry[DW-3:0],key_sym}, cnt=1, go to ENTRY.
  - chg (without key_vld): chg_mode=1, go to ENTRY. The current code must be verified first.
- ENTRY:
  - Each key_vld shifts in key_sym and increments cnt.
  - When cnt reaches DW/2, go to CHECK on the next edge.
- CHECK: one cycle; compares entry with code.
  - Match, chg_mode=1: go to NEW_ENTRY, clear entry and cnt.
  - Match, chg_mode=0: go to HOLD_P, tries=0.
  - Mismatch, tries+1 < MAX_TRY: tries++, go to HOLD_F, chg_mode=0.
  - Mismatch, tries+1 = MAX_TRY: go to LOCK, chg_mode=0.
- Latency: last symbol strobed at edge t; CHECK occupies cycle t+1; pass or fail is high from edge t+2.
- HOLD_P:
  - pass=1 for exactly HOLD_CYC cycles.
  - Then IDLE; entry, cnt and chg_mode cleared.
- HOLD_F:
  - fail=1 for exactly HOLD_CYC cycles.
  - Then IDLE; entry and cnt cleared.
- LOCK:
  - locked=1 and fail=1 for exactly LOCK_CYC cycles.
  - Then IDLE with tries=0.
  - key_vld, clr and chg are all ignored.
- NEW_ENTRY:
  - Collects DW/2 symbols exactly as ENTRY does.
  - On the edge after the last symbol: code=entry, chg_mode=0, go to HOLD_P.
  - tries is not modified.
- clr:
  - Effective in ENTRY and NEW_ENTRY only.
  - Goes to IDLE; clears entry, cnt and chg_mode.
  - Not counted as a failure; tries is unchanged.
- Simultaneous events:
  - clr with key_vld: clr wins and the symbol is dropped.
  - chg with key_vld in IDLE: key_vld wins and chg is ignored.
  - chg outside IDLE: ignored.
- key_vld in CHECK, HOLD_P, HOLD_F or LOCK: ignored, with no queuing.
- Outputs are registered, and pass and fail are never high together.
- Timer: a single down-counter shared by HOLD_P, HOLD_F and LOCK. Width is ceil(log2(max(LOCK_CYC,HOLD_CYC)))+1 bits.

Test Plan:
All scenarios use the defaults: DW=8, MAX_TRY=3, LOCK_CYC=16, HOLD_CYC=8.
- Reset, then keys 3,3,3,3 → cnt steps 1..4, entry=8'hFF. CHECK follows, then pass=1 for exactly 8 cycles from the second edge after the last key; tries stays 0.
- Keys 0,1,2,3 twice → each attempt gives fail=1 for 8 cycles and tries steps 1, then 2. Then keys 3,3,3,3 → pass=1 and tries=0.
- Three wrong attempts → the third gives locked=1 and fail=1 for 16 cycles. key_vld pulses during lockout leave entry and cnt at 0. Afterwards tries=0 and state is IDLE.
- chg, then keys 3,3,3,3, then 1,2,0,3 → chg_mode=1 throughout. code=8'h63 on the edge after the final key, then pass for 8 cycles. Old code 3,3,3,3 now fails; 1,2,0,3 now passes.
- chg, then a wrong verification 0,0,0,0 → fail, chg_mode=0, code unchanged at 8'hFF, tries=1.
- Keys 1,2, then clr asserted together with key_vld → entry=0, cnt=0, tries unchanged. rst asserted during LOCK → all outputs return to reset values on the next edge.
